// File: rtl/prng_pkg.sv
// prng_pkg: shared constants, FSM state type and the LFSR step function for
// the PRNG request scheduler.
//   LFSR_W     LFSR width
//   LFSR_TAPS  Galois tap mask for x^16+x^14+x^13+x^11+1
//   state_t    scheduler states
//   lfsr_next  one right-shifting Galois step
package prng_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WARM  = 2'd1,
    SERVE = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    logic [LFSR_W-1:0] s;
    s = l >> 1;
    if (l[0]) s = s ^ LFSR_TAPS;
    return s;
  endfunction

endpackage

// File: rtl/prng_req_scheduler_if.sv
// prng_req_scheduler_if: control, request and result signals between the pin
// decode logic (master) and the PRNG request scheduler (slave).
//   ena, seed_we, seed_in, req    master -> slave
//   gnt, rnd_valid, rnd_data, busy slave -> master
interface prng_req_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import prng_pkg::*;

  logic               ena;
  logic               seed_we;
  logic [LFSR_W-1:0]  seed_in;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               rnd_valid;
  logic [7:0]         rnd_data;
  logic               busy;

  modport master (
    output ena, seed_we, seed_in, req,
    input  gnt, rnd_valid, rnd_data, busy
  );

  modport slave (
    input  ena, seed_we, seed_in, req,
    output gnt, rnd_valid, rnd_data, busy
  );

endinterface

// File: rtl/prng_lfsr16.sv
// prng_lfsr16: 16-bit Galois LFSR register.
//   clk, rst   clock, async active-high reset (loads SEED)
//   load       load load_val (takes priority over step)
//   load_val   value to load; caller guarantees it is non-zero
//   step       advance one LFSR step
//   value      current LFSR contents
module prng_lfsr16
  import prng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= SEED;
    else if (load) value <= load_val;
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/prng_req_scheduler.sv
// prng_req_scheduler: owns the LFSR, sequences seed load and warm-up, then
// grants one requester per cycle round-robin, returning LFSR[15:8] and
// stepping the LFSR once per grant.
//   clk, rst   clock, async active-high reset
//   bus        slave modport: ena, seed_we, seed_in, req in;
//              gnt, rnd_valid, rnd_data, busy out
module prng_req_scheduler
  import prng_pkg::*;
#(
  parameter int                NUM_REQ = 4,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int                WARMUP  = 16
) (
  input  logic                clk,
  input  logic                rst,
  prng_req_scheduler_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [7:0]         warm_cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  load_val;
  logic               lfsr_load, lfsr_step;
  logic               grant;
  logic               found;
  logic [PTR_W-1:0]   sel;
  int                 idx;
  logic [NUM_REQ-1:0] gnt_q;
  logic               valid_q;
  logic [7:0]         data_q;

  // A zero seed would lock the LFSR, so it is replaced by SEED.
  assign load_val = (bus.seed_in == '0) ? SEED : bus.seed_in;

  prng_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (load_val),
    .step     (lfsr_step),
    .value    (lfsr)
  );

  // First set request at or after rr_ptr, wrapping by compare.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WARM;
    else     state <= state_nxt;
  end

  // seed_we wins over everything, including a pending grant.
  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    grant     = 1'b0;
    if (bus.ena) begin
      if (bus.seed_we) begin
        state_nxt = LOAD;
      end else begin
        case (state)
          LOAD: begin
            lfsr_load = 1'b1;
            state_nxt = WARM;
          end
          WARM: begin
            lfsr_step = 1'b1;
            if (warm_cnt == 8'(WARMUP - 1)) state_nxt = SERVE;
          end
          SERVE: begin
            grant     = found;
            lfsr_step = found;
          end
          default: state_nxt = WARM;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
    end else if (bus.ena && !bus.seed_we) begin
      if (state == LOAD)      warm_cnt <= '0;
      else if (state == WARM) warm_cnt <= warm_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      if (grant) begin
        gnt_q   <= NUM_REQ'(1) << sel;
        valid_q <= 1'b1;
        data_q  <= lfsr[15:8];
        rr_ptr  <= (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rnd_valid = valid_q;
  assign bus.rnd_data  = data_q;
  assign bus.busy      = (state != SERVE);

endmodule

// File: tb/tb_prng_req_scheduler.sv
module tb_prng_req_scheduler;
  import prng_pkg::*;

  localparam int N = 4;
  localparam logic [15:0] TB_SEED = 16'h0001;
  localparam int TB_WARM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prng_req_scheduler_if #(.NUM_REQ(N)) bus ();
  prng_req_scheduler_if #(.NUM_REQ(N)) bus2 ();

  prng_req_scheduler #(.NUM_REQ(N), .SEED(TB_SEED), .WARMUP(TB_WARM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  prng_req_scheduler dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Specification-level model: polynomial step, warm-up as a count of
  // remaining steps, arbitration as a modulo scan from the pointer.
  function automatic logic [15:0] spec_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  int          m_phase = 1;  // 0 load pending, 1 warming, 2 serving
  int          m_warm_left = TB_WARM;
  int          m_ptr = 0;
  logic [15:0] m_lfsr = TB_SEED;
  logic [N-1:0] e_gnt = '0;
  logic        e_valid = 1'b0;
  logic [7:0]  e_data = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 1; m_warm_left = TB_WARM; m_ptr = 0; m_lfsr = TB_SEED;
      e_gnt = '0; e_valid = 1'b0; e_data = 8'h00;
    end else begin
      e_gnt = '0;
      e_valid = 1'b0;
      if (bus.ena) begin
        if (bus.seed_we) begin
          m_phase = 0;
        end else if (m_phase == 0) begin
          m_lfsr = (bus.seed_in == 16'h0) ? TB_SEED : bus.seed_in;
          m_warm_left = TB_WARM;
          m_phase = 1;
        end else if (m_phase == 1) begin
          m_lfsr = spec_step(m_lfsr);
          m_warm_left--;
          if (m_warm_left == 0) m_phase = 2;
        end else begin
          for (int k = 0; k < N; k++) begin
            if (!e_valid && bus.req[(m_ptr + k) % N]) begin
              e_valid = 1'b1;
              e_gnt[(m_ptr + k) % N] = 1'b1;
              e_data = m_lfsr[15:8];
              m_lfsr = spec_step(m_lfsr);
              m_ptr = (m_ptr + k + 1) % N;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_gnt", 32'(bus.gnt), 32'(e_gnt));
      check("m_valid", 32'(bus.rnd_valid), 32'(e_valid));
      check("m_data", 32'(bus.rnd_data), 32'(e_data));
      check("m_busy", 32'(bus.busy), 32'(m_phase != 2));
      check("m_lfsr", 32'(dut.u_lfsr.value), 32'(m_lfsr));
    end
  end

  initial begin
    logic [7:0] t2_data [3];
    logic [N-1:0] t3_gnt [5];
    logic [15:0] saved;
    bit seen;
    t2_data = '{8'h5A, 8'h2D, 8'h16};
    t3_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    bus.ena = 1'b1; bus.seed_we = 1'b0; bus.seed_in = 16'h0; bus.req = '0;
    bus2.ena = 1'b1; bus2.seed_we = 1'b0; bus2.seed_in = 16'h0; bus2.req = 4'b1111;

    repeat (2) @(negedge clk);
    check("t1_rst_gnt", 32'(bus.gnt), 32'h0);
    check("t1_rst_data", 32'(bus.rnd_data), 32'h0);
    rst = 1'b0;
    rst2 = 1'b0;
    #1 check("t1_busy_c0", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("t1_busy_c1", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("t1_busy_c2", 32'(bus.busy), 32'h0);
    check("t1_lfsr", 32'(dut.u_lfsr.value), 32'h5A00);

    bus.req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_gnt", 32'(bus.gnt), 32'h1);
      check("t2_data", 32'(bus.rnd_data), 32'(t2_data[i]));
    end

    // Grant requester 3 so the pointer wraps back to 0.
    bus.req = 4'b1000;
    @(negedge clk);
    check("t3_pre_gnt", 32'(bus.gnt), 32'h8);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_gnt", 32'(bus.gnt), 32'(t3_gnt[i]));
      check("t3_valid", 32'(bus.rnd_valid), 32'h1);
    end

    bus.req = 4'b0010; bus.seed_in = 16'h0000; bus.seed_we = 1'b1;
    @(negedge clk);
    check("t4_gnt", 32'(bus.gnt), 32'h0);
    check("t4_valid", 32'(bus.rnd_valid), 32'h0);
    check("t4_busy", 32'(bus.busy), 32'h1);
    bus.seed_we = 1'b0;
    @(negedge clk);
    check("t4_reload", 32'(dut.u_lfsr.value), 32'h0001);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.rnd_valid) begin
        seen = 1'b1;
        check("t4_first_data", 32'(bus.rnd_data), 32'h5A);
        check("t4_first_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
      end
    end
    if (!seen) check("t4_timeout", 32'h0, 32'h1);

    @(negedge clk);
    saved = dut.u_lfsr.value;
    bus.ena = 1'b0; bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_gnt", 32'(bus.gnt), 32'h0);
      check("t5_valid", 32'(bus.rnd_valid), 32'h0);
      check("t5_lfsr", 32'(dut.u_lfsr.value), 32'(saved));
    end
    bus.ena = 1'b1;
    @(negedge clk);
    check("t5_resume_gnt", 32'(bus.gnt), 32'h4);
    check("t5_resume_valid", 32'(bus.rnd_valid), 32'h1);
    bus.req = '0;
    @(negedge clk);

    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus2.rnd_valid) seen = 1'b1;
    end
    if (!seen) check("t6_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #2 rst2 = 1'b1;
    #1;
    check("t6_gnt", 32'(bus2.gnt), 32'h0);
    check("t6_valid", 32'(bus2.rnd_valid), 32'h0);
    check("t6_data", 32'(bus2.rnd_data), 32'h0);
    check("t6_busy", 32'(bus2.busy), 32'h1);
    check("t6_lfsr", 32'(dut2.u_lfsr.value), 32'hACE1);
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    check("t6_step", 32'(dut2.u_lfsr.value), 32'hE270);
    check("t6_gnt_after", 32'(bus2.gnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
